// File: rtl/fft_seg_pkg.sv
// rtl/fft_seg_pkg.sv - shared types and helper functions for the PISO segment buffer
//
// Purpose : state and stage-select encodings, plus constant functions used at
//           elaboration time (clog2, bit-reversal of an index).
// Ports   : none (package).
// Macro   : PISO_BITREV_EN (consumed by piso_segment_buffer; bitrev() is used there).

package fft_seg_pkg;

  // Buffer occupancy state: EMPTY means count==0, STREAM means count>0.
  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } seg_state_e;

  // Per-stage register update select.
  typedef enum logic [1:0] {
    SEL_KEEP  = 2'd0,
    SEL_LOAD  = 2'd1,
    SEL_SHIFT = 2'd2
  } stage_sel_e;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Reverse the low nbits bits of index.
  function automatic int bitrev(input int index, input int nbits);
    int r;
    r = 0;
    for (int b = 0; b < nbits; b++) begin
      r = r | (((index >> b) & 1) << (nbits - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_stage.sv
// rtl/piso_stage.sv - one word register of the PISO chain with load/shift/keep select
//
// Purpose : holds one DATA_WIDTH word; takes the parallel word on load, the
//           neighbouring stage (or chain input) on shift, otherwise keeps.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-low reset, clears the word
//           sel        - SEL_KEEP / SEL_LOAD / SEL_SHIFT
//           load_word  - word taken on load
//           shift_word - word taken on shift
//           q          - stored word

module piso_stage
  import fft_seg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic [DATA_WIDTH-1:0] shift_word,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOAD:  q <= load_word;
        SEL_SHIFT: q <= shift_word;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/piso_segment_buffer.sv
// rtl/piso_segment_buffer.sv - parallel-in/serial-out segment buffer with valid/ready output
//
// Purpose : captures a DEPTH-word frame in one cycle and streams it out word 0
//           first, one word per accepted transfer. A frame may be loaded on the
//           same edge as the last word of the previous frame leaves, so
//           consecutive frames stream without a bubble. ser_in fills the top
//           stage on every shift so segments can be cascaded.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-low reset
//           hold       - freeze: no load, no shift, no count change
//           load_data  - parallel frame, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//           load_valid - frame present on load_data
//           load_ready - frame accepted this cycle if load_valid
//           ser_in     - chain input shifted into stage DEPTH-1
//           out_data   - head word (stage 0)
//           out_valid  - head word valid
//           out_ready  - downstream accepts out_data
//           out_last   - head word is the final word of the frame
//           count      - words remaining, including the head
// Macro   : PISO_BITREV_EN - when defined, stage i loads word bitrev(i) so the
//           frame leaves in bit-reversed order; DEPTH must be a power of two.

module piso_segment_buffer
  import fft_seg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [DEPTH*DATA_WIDTH-1:0] load_data,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [DATA_WIDTH-1:0]       ser_in,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [CNT_W-1:0]            count
);

  seg_state_e             state_q;
  seg_state_e             state_d;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  stage_sel_e             stage_sel;
  logic                   shift;
  logic                   load;
  logic [DATA_WIDTH-1:0]  stage_q [DEPTH];

  if (DEPTH < 2) begin : g_depth_check
    $error("piso_segment_buffer: DEPTH must be at least 2");
  end

`ifdef PISO_BITREV_EN
  localparam int LOG2_DEPTH = clog2(DEPTH);
  if ((1 << LOG2_DEPTH) != DEPTH) begin : g_pow2_check
    $error("piso_segment_buffer: DEPTH must be a power of two with PISO_BITREV_EN");
  end
`endif

  // Handshake. hold masks out_valid, which in turn blocks shift and the
  // back-to-back load path, so hold needs no separate term there.
  always_comb begin
    out_valid  = (state_q == ST_STREAM) & ~hold;
    out_last   = out_valid & (count_q == CNT_W'(1));
    shift      = out_valid & out_ready;
    load_ready = ~hold & ((state_q == ST_EMPTY) | (shift & out_last));
    load       = load_valid & load_ready;
  end

  // Next-state, counter and stage select. Load has priority over shift: on
  // the last-word transfer both are true and the new frame replaces the chain.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    stage_sel = SEL_KEEP;
    if (load) begin
      state_d   = ST_STREAM;
      count_d   = CNT_W'(DEPTH);
      stage_sel = SEL_LOAD;
    end else if (shift) begin
      stage_sel = SEL_SHIFT;
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end
      if (count_q <= CNT_W'(1)) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
`ifdef PISO_BITREV_EN
    localparam int SRC = bitrev(i, LOG2_DEPTH);
`else
    localparam int SRC = i;
`endif
    logic [DATA_WIDTH-1:0] shift_word;

    if (i == DEPTH - 1) begin : g_top
      assign shift_word = ser_in;
    end else begin : g_mid
      assign shift_word = stage_q[i+1];
    end

    piso_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .sel       (stage_sel),
      .load_word (load_data[SRC*DATA_WIDTH +: DATA_WIDTH]),
      .shift_word(shift_word),
      .q         (stage_q[i])
    );
  end

  assign out_data = stage_q[0];
  assign count    = count_q;

endmodule

// File: tb/tb_piso_segment_buffer.sv
// tb/tb_piso_segment_buffer.sv - self-checking bench for piso_segment_buffer
//
// Purpose : directed scenarios plus randomized traffic, each cycle compared
//           against a queue-based model of the frame buffer.
// Macro   : PISO_BITREV_EN - selects bit-reversed expected output order.

module tb_piso_segment_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = 3 + CW + DW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  hold = 1'b0;
  logic [DEPTH*DW-1:0]   load_data = '0;
  logic                  load_valid = 1'b0;
  logic                  load_ready;
  logic [DW-1:0]         ser_in = '0;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  out_last;
  logic [CW-1:0]         count;

  piso_segment_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .ser_in    (ser_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .count     (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: the eight stage contents in output order and the words remaining.
  logic [DW-1:0] m_stage[$];
  int            m_count;
  logic [DW-1:0] dut_seen[$];
  int            dut_cyc[$];

  // Which frame word ends up at stage position j.
  function automatic int order(input int j);
`ifdef PISO_BITREV_EN
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
`else
    return j;
`endif
  endfunction

  function automatic logic [DEPTH*DW-1:0] mk_frame(input logic [DW-1:0] base);
    logic [DEPTH*DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = base + DW'(i);
    return f;
  endfunction

  function automatic logic [DEPTH*DW-1:0] rnd_frame();
    logic [DEPTH*DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = $urandom;
    return f;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {out_valid, out_last, load_ready, count, out_data};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic ov, ol, lr;
    ov = (m_count > 0) && !hold;
    ol = ov && (m_count == 1);
    lr = !hold && ((m_count == 0) || (ov && out_ready && m_count == 1));
    return {ov, ol, lr, CW'(m_count), m_stage[0]};
  endfunction

  task automatic model_reset();
    m_stage.delete();
    for (int i = 0; i < DEPTH; i++) m_stage.push_back('0);
    m_count = 0;
  endtask

  task automatic drive(input logic h, input logic lv, input logic orr,
                       input logic [DW-1:0] si, input logic [DEPTH*DW-1:0] ld);
    @(negedge clk);
    hold       = h;
    load_valid = lv;
    out_ready  = orr;
    ser_in     = si;
    load_data  = ld;
    #1;
    if (out_valid && out_ready) begin
      dut_seen.push_back(out_data);
      dut_cyc.push_back(cyc);
    end
  endtask

  task automatic advance(output bit loaded);
    bit sh, ld;
    logic [DW-1:0] si;
    logic [DEPTH*DW-1:0] fr;
    sh = (m_count > 0) && !hold && out_ready;
    ld = load_valid && !hold && ((m_count == 0) || (sh && m_count == 1));
    si = ser_in;
    fr = load_data;
    @(posedge clk);
    cyc++;
    if (ld) begin
      for (int j = 0; j < DEPTH; j++) m_stage[j] = fr[order(j)*DW +: DW];
      m_count = DEPTH;
    end else if (sh) begin
      void'(m_stage.pop_front());
      m_stage.push_back(si);
      m_count--;
    end
    loaded = ld;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, count, out_data} !== {1'b0, 1'b0, CW'(0), DW'(0)}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {out_valid, out_last, count, out_data}, {1'b0, 1'b0, CW'(0), DW'(0)});
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_load_ready got=%b want=1", load_ready);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reset_vec got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_frame();
    bit l;
    dut_seen.delete();
    drive(0, 1, 1, $urandom, mk_frame(32'h10));
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL sf_load got=%h want=%h", obs_vec(), exp_vec());
    end
    advance(l);
    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 1, $urandom, rnd_frame());
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL sf_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      advance(l);
    end
    total++;
    if (dut_seen.size() != DEPTH) begin
      bad++;
      $display("FAIL sf_word_count got=%0d want=%0d", dut_seen.size(), DEPTH);
    end
    for (int i = 0; i < dut_seen.size() && i < DEPTH; i++) begin
      total++;
      if (dut_seen[i] !== 32'h10 + DW'(order(i))) begin
        bad++;
        $display("FAIL sf_word%0d got=%h want=%h", i, dut_seen[i], 32'h10 + DW'(order(i)));
      end
    end
  endtask

  task automatic test_backpressure();
    bit l;
    int n;
    logic [3:0] pat;
    logic [DEPTH*DW-1:0] fr;
    pat = 4'b1001;
    fr  = rnd_frame();
    dut_seen.delete();
    drive(0, 1, 1, $urandom, fr);
    advance(l);
    n = 0;
    while (m_count > 0 && n < 60) begin
      drive(0, 0, pat[n % 4], $urandom, rnd_frame());
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bp_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      advance(l);
      n++;
    end
    total++;
    if (m_count != 0) begin
      bad++;
      $display("FAIL bp_timeout got=%0d want=0", m_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (i >= dut_seen.size() || dut_seen[i] !== fr[order(i)*DW +: DW]) begin
        bad++;
        $display("FAIL bp_word%0d got=%h want=%h", i, (i < dut_seen.size()) ? dut_seen[i] : 'x, fr[order(i)*DW +: DW]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit l;
    bit lv;
    int n;
    logic [DW-1:0] base;
    lv   = 1'b1;
    base = 32'hA0;
    n    = 0;
    dut_seen.delete();
    dut_cyc.delete();
    while ((lv || m_count > 0) && n < 40) begin
      drive(0, lv, 1, $urandom, mk_frame(base));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      advance(l);
      if (l) begin
        if (base == 32'hA0) base = 32'hB0;
        else lv = 1'b0;
      end
      n++;
    end
    total++;
    if (dut_seen.size() != 2 * DEPTH) begin
      bad++;
      $display("FAIL b2b_word_count got=%0d want=%0d", dut_seen.size(), 2 * DEPTH);
    end
    for (int i = 0; i < dut_seen.size() && i < 2 * DEPTH; i++) begin
      total++;
      if (dut_seen[i] !== ((i < DEPTH) ? 32'hA0 : 32'hB0) + DW'(order(i % DEPTH))) begin
        bad++;
        $display("FAIL b2b_word%0d got=%h want=%h", i, dut_seen[i], ((i < DEPTH) ? 32'hA0 : 32'hB0) + DW'(order(i % DEPTH)));
      end
    end
    if (dut_cyc.size() > DEPTH) begin
      total++;
      if (dut_cyc[DEPTH] != dut_cyc[DEPTH-1] + 1) begin
        bad++;
        $display("FAIL b2b_bubble got=%0d want=%0d", dut_cyc[DEPTH], dut_cyc[DEPTH-1] + 1);
      end
    end
  endtask

  task automatic test_hold();
    bit l;
    int n;
    logic [DEPTH*DW-1:0] fr;
    fr = rnd_frame();
    dut_seen.delete();
    drive(0, 1, 1, $urandom, fr);
    advance(l);
    n = 0;
    while (m_count != 5 && n < 20) begin
      drive(0, 0, 1, $urandom, rnd_frame());
      advance(l);
      n++;
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, $urandom, rnd_frame());
      total++;
      if ({out_valid, load_ready, count} !== {1'b0, 1'b0, CW'(5)}) begin
        bad++;
        $display("FAIL hold_cycle%0d got=%h want=%h", c, {out_valid, load_ready, count}, {1'b0, 1'b0, CW'(5)});
      end
      advance(l);
    end
    n = 0;
    while (m_count > 0 && n < 20) begin
      drive(0, 0, 1, $urandom, rnd_frame());
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL hold_resume%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      advance(l);
      n++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (i >= dut_seen.size() || dut_seen[i] !== fr[order(i)*DW +: DW]) begin
        bad++;
        $display("FAIL hold_word%0d got=%h want=%h", i, (i < dut_seen.size()) ? dut_seen[i] : 'x, fr[order(i)*DW +: DW]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit l;
    drive(0, 1, 1, $urandom, rnd_frame());
    advance(l);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, $urandom, rnd_frame());
      advance(l);
    end
    drive(0, 0, 1, $urandom, rnd_frame());
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, count, out_data} !== {1'b0, 1'b0, CW'(0), DW'(0)}) begin
      bad++;
      $display("FAIL arst_immediate got=%h want=%h", {out_valid, out_last, count, out_data}, {1'b0, 1'b0, CW'(0), DW'(0)});
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (load_ready !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL arst_release got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit l;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 6) == 0, $urandom % 2, ($urandom % 4) != 0, $urandom, rnd_frame());
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rand_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      advance(l);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_segment_buffer.md
Name: piso_segment_buffer

Overview:
- Parametrised parallel-in/serial-out segment buffer for the FFT commutator path; supersedes the fixed 8-deep load/shift DFF segment.
- Captures a DEPTH-word frame in one cycle, then streams it out one word per accepted transfer under a valid/ready handshake.
- Tracks a remaining-word count and flags the last word, so back-to-back frames run without bubbles.
- A serial chain input fills the vacated top stage, which allows segments to be cascaded.

Parameters:
- DATA_WIDTH, 32: width of one word (complex sample, packed).
- DEPTH, 8: number of words per frame; must be ≥2.
- CNT_W, $clog2(DEPTH+1): width of the remaining-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- hold  input  1  freeze: no load, no shift, no count change.
- load_data  input  DEPTH*DATA_WIDTH  parallel frame; word i is at [i*DATA_WIDTH +: DATA_WIDTH]; word 0 is emitted first.
- load_valid  input  1  frame present on load_data.
- load_ready  output  1  buffer can accept a frame this cycle.
- ser_in  input  DATA_WIDTH  chain input shifted into stage DEPTH-1 on each shift.
- out_data  output  DATA_WIDTH  current head word, equal to stage 0.
- out_valid  output  1  head word is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  head word is the final word of the frame.
- count  output  CNT_W  words remaining, including the head.

Behaviour:
- Reset (rst low, async): all stages 0, count 0, state EMPTY, out_valid 0, out_last 0. After release, load_ready=1 whenever hold=0.
- States:
  - EMPTY (count==0).
  - STREAM (count>0).
- Derived signals:
  - shift = out_valid & out_ready & !hold.
  - load = load_valid & load_ready.
  - load_ready = !hold & (EMPTY | (shift & out_last)). This is combinational and allows back-to-back frames.
  - out_valid = (STREAM) & !hold.
  - out_last = (count==1) & out_valid.
- Load: at the edge where load is true, stage i ← word i, count ← DEPTH, state → STREAM. First word is valid one cycle after acceptance (latency 1).
- Shift (without load): stage k ← stage k+1 for k<DEPTH-1, stage DEPTH-1 ← ser_in, count ← count-1. When count reaches 0, state → EMPTY.
- Simultaneous last-word shift and load: the load wins and the new frame's word 0 appears next cycle with no bubble. The old last word is still counted as transferred.
- load_valid while STREAM and not at the last transfer: ignored (load_ready=0); the upstream producer must hold its frame.
- hold=1: all registers keep their values, out_valid and load_ready read 0, and no transfer occurs even if out_ready=1.
- out_ready=0 while STREAM: head and count are stable; out_data must not change.
- rst asserted mid-frame: the frame is discarded immediately and the block returns to the reset state.
- count never underflows; it saturates at 0 in EMPTY.

Optional Feature:
- Macro: PISO_BITREV_EN.
- Defined: on load, stage i ← word bitrev(i) over log2(DEPTH) bits. DEPTH must be a power of two; elaboration fails with $error otherwise. The output stream is therefore in bit-reversed order, as needed for the FFT output reorder.
- Undefined: natural order, as specified above. No extra logic is generated.

Decomposition:
- Package fft_seg_pkg:
  - clog2 function.
  - bitrev function (index, bit count).
  - State encoding constants ST_EMPTY=1'b0, ST_STREAM=1'b1.
- Sub-module piso_stage: one DATA_WIDTH register with async active-low reset and a load/shift/keep select. It is instantiated DEPTH times in a generate loop.
- The top level holds the FSM, counter and handshake logic.

Test Plan:
- Reset, then one frame: DEPTH=8, load words 0x10..0x17, out_ready=1. Expect out_data 0x10..0x17 on 8 consecutive cycles starting 1 cycle after the load. out_last high only with 0x17. count goes 8→1, then 0.
- Backpressure: toggle out_ready 1,0,0,1 during a frame. Expect out_data and count stable while out_ready=0, no words lost or repeated, and load_ready=0 throughout.
- Back-to-back frames: hold load_valid high with frame A (0xA0..) and then frame B (0xB0..). Expect 0xA7 followed immediately by 0xB0, with no idle cycle; load_ready pulses on the 0xA7 transfer cycle.
- Hold: assert hold for 3 cycles mid-frame at count=5. Expect out_valid=0, count=5 and stages unchanged, then resume with the next word.
- Async reset: drop rst mid-frame between clock edges. Expect out_valid=0 and count=0 immediately; after release, load_ready=1.
- PISO_BITREV_EN: DEPTH=8, load words 0..7. Expect output order 0,4,2,6,1,5,3,7. ser_in=0xFF should appear in stage 7 after the first shift (visible on out_data only via a cascaded-segment test).
